health_mux_scheduler: RTL and testbench
=======================================

Name: health_mux_scheduler

Overview:
- Round-robin scheduler that shares one 4:1 health-signal mux (i0..i3, E, s0, s1 -> y) between four sensor channels.
- Grants one requesting channel at a time, drives the mux select/enable lines, waits a settle interval, then samples y.
- Tracks consecutive fault samples per channel and raises sticky alarms.
- Sits between the sensor-request logic and the mux, and feeds the health-status register block.

Parameters:
- SETTLE_CYCLES, 2: cycles mux_e is held before sampling; legal range 1..15.
- ALARM_THRESH, 3: consecutive fault samples (y=1) that set an alarm; legal range 1..15.
- CNT_W, 4: width of settle and fault counters; must hold both parameters.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- en  in  1  scheduler enable; sampled in IDLE only
- req  in  4  per-channel sample request, level-sensitive
- mux_y  in  1  output y of the 4:1 mux
- mux_s0  out  1  mux select bit 0
- mux_s1  out  1  mux select bit 1
- mux_e  out  1  mux enable E
- gnt  out  4  one-hot current grant; 0 when idle
- busy  out  1  high whenever the state is not IDLE
- smp_valid  out  1  one-cycle pulse that marks a new sample
- smp_ch  out  2  channel of the last sample
- smp_bit  out  1  value of the last sample
- alarm  out  4  sticky per-channel alarm
- alarm_clr  in  4  per-channel alarm and fault-counter clear

Behaviour:
- All outputs are registered.
- Reset: state IDLE; mux_s0/mux_s1/mux_e/gnt/busy/smp_valid/smp_ch/smp_bit/alarm = 0; fault counters = 0; last-served pointer ptr = 3, so ch0 wins first.
- FSM states: IDLE, SETTLE, SAMPLE.
- IDLE:
  - mux_e=0, gnt=0.
  - If en=1 and req!=0, pick the first requesting channel scanning ptr+1, ptr+2, ... mod 4.
  - Register {mux_s1,mux_s0}=ch and gnt=1<<ch; load the settle counter with SETTLE_CYCLES-1; go to SETTLE.
- SETTLE:
  - mux_e=1, select held stable.
  - Decrement the counter; at 0 go to SAMPLE.
- SAMPLE:
  - mux_e=1.
  - On the clock edge: smp_bit<=mux_y, smp_ch<=ch, smp_valid<=1 for exactly one cycle, ptr<=ch, update the fault counter; go to IDLE.
- Leaving SAMPLE drops mux_e and gnt, giving one disabled cycle before any select change (break-before-make).
- Latency: req seen in IDLE at cycle t -> SETTLE t+1..t+SETTLE_CYCLES -> SAMPLE t+SETTLE_CYCLES+1 -> smp_valid high at t+SETTLE_CYCLES+2.
- Back-to-back period is SETTLE_CYCLES+2 cycles.
- Fault counter per channel:
  - Sample 1 increments, saturating at ALARM_THRESH.
  - Sample 0 clears to 0.
  - alarm[ch] sets on the sample that makes count == ALARM_THRESH and stays set until alarm_clr[ch].
- alarm_clr[i] clears alarm[i] and counter i in the next cycle.
- alarm_clr[i] in the same cycle as a set of alarm[i]: set wins and the counter holds at threshold.
- req deasserts mid-transaction: the transaction completes and the sample is still reported.
- en deasserts mid-transaction: the transaction completes, then the FSM stays in IDLE.
- rst mid-transaction: all state returns to reset values on that edge; no smp_valid is issued.

Optional Feature:
- Macro: HEALTH_SCHED_FIXED_PRIORITY_EN.
- Defined: IDLE grants the lowest-index requesting channel; ptr is still updated but ignored.
- Undefined: round-robin as above (default).

Test Plan:
- Reset mid-SETTLE: SETTLE_CYCLES=2, req=4'b1111, rst high 2 cycles during SETTLE -> all outputs 0, no smp_valid, next grant gnt=4'b0001.
- Round-robin: req=4'b1111, mux_y=0, SETTLE_CYCLES=2 -> smp_ch sequence 0,1,2,3,0, smp_valid every 4 cycles, first smp_valid 4 cycles after the first IDLE cycle.
- Select mapping: req=4'b0100 -> mux_s1=1, mux_s0=0, mux_e=1, gnt=4'b0100 for exactly 3 cycles, then mux_e=0 for at least 1 cycle; smp_bit equals mux_y in the SAMPLE cycle.
- Alarm threshold: req=4'b0100, mux_y sequence 1,1,0,1,1,1 -> alarm[2]=0 through sample 5, alarm[2]=1 after the 6th smp_valid, sticky after mux_y=0.
- Clear/set collision: alarm_clr[2]=1 in the same cycle the 3rd consecutive fault sample lands -> alarm[2] remains 1; a later alarm_clr[2] -> alarm=0 and counter 0.
- Enable drop: en falls in the first SETTLE cycle with req=4'b0011 -> exactly one smp_valid (ch0), then busy=0 and gnt=0 while en=0.

Source files
------------

// File: rtl/health_mux_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : health_mux_scheduler
// Purpose  : Round-robin scheduler that time-shares one 4:1 health-signal mux
//            (i0..i3, E, s0, s1 -> y) between four sensor channels. A grant
//            drives the select lines, holds E for a settle interval, samples
//            y once, then drops E before any select change (break-before-make).
//            Consecutive fault samples (y=1) per channel are counted and
//            raise sticky alarms.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            en                 - scheduler enable, honoured in IDLE only
//            req[3:0]           - level-sensitive per-channel sample request
//            mux_y              - mux output y
//            mux_s0/mux_s1/mux_e- mux select bits and enable
//            gnt[3:0]           - one-hot grant, 0 when idle
//            busy               - high whenever not IDLE
//            smp_valid          - one-cycle pulse marking a new sample
//            smp_ch/smp_bit     - channel and value of the last sample
//            alarm[3:0]         - sticky per-channel alarm
//            alarm_clr[3:0]     - per-channel alarm and fault-counter clear
// Options  : HEALTH_SCHED_FIXED_PRIORITY_EN - when defined, IDLE grants the
//            lowest-index requester instead of rotating.
// Revision : 1.0 - initial release
// ============================================================================
module health_mux_scheduler #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ALARM_THRESH  = 3,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    input  logic       mux_y,
    output logic       mux_s0,
    output logic       mux_s1,
    output logic       mux_e,
    output logic [3:0] gnt,
    output logic       busy,
    output logic       smp_valid,
    output logic [1:0] smp_ch,
    output logic       smp_bit,
    output logic [3:0] alarm,
    input  logic [3:0] alarm_clr
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;

    localparam logic [CNT_W-1:0] c_settle_load = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_thresh      = CNT_W'(ALARM_THRESH);
    localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_settle_cnt;
    logic [1:0]       r_ch;
    logic [1:0]       r_ptr;
    logic             r_mux_e;
    logic [3:0]       r_gnt;
    logic             r_busy;
    logic             r_smp_valid;
    logic [1:0]       r_smp_ch;
    logic             r_smp_bit;
    logic [3:0]       w_alarm;

    logic             w_pick_vld;
    logic [1:0]       w_pick_ch;
    logic [1:0]       w_scan_idx;
    logic             w_start;
    logic             w_sample;

    // ------------------------------------------------------------------
    // Channel selection. The loop walks the scan order backwards so the
    // last overwrite is the first requester in priority order.
    // ------------------------------------------------------------------
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_ch  = 2'd0;
        w_scan_idx = 2'd0;
`ifdef HEALTH_SCHED_FIXED_PRIORITY_EN
        for (int k = 3; k >= 0; k--) begin
            w_scan_idx = 2'(k);
            if (req[w_scan_idx]) begin
                w_pick_vld = 1'b1;
                w_pick_ch  = w_scan_idx;
            end
        end
`else
        // Scan ptr+1, ptr+2, ptr+3, ptr (2-bit wrap gives the modulo).
        for (int k = 4; k >= 1; k--) begin
            w_scan_idx = r_ptr + 2'(k);
            if (req[w_scan_idx]) begin
                w_pick_vld = 1'b1;
                w_pick_ch  = w_scan_idx;
            end
        end
`endif
    end

    assign w_start  = (r_state == S_IDLE) && en && w_pick_vld;
    assign w_sample = (r_state == S_SAMPLE);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_state_nxt = S_SETTLE;
            S_SETTLE: if (r_settle_cnt == '0) w_state_nxt = S_SAMPLE;
            S_SAMPLE: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register and registered mux/sample outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_settle_cnt <= '0;
            r_ch         <= 2'd0;
            r_ptr        <= 2'd3;    // ch0 wins the first arbitration
            r_mux_e      <= 1'b0;
            r_gnt        <= 4'b0000;
            r_busy       <= 1'b0;
            r_smp_valid  <= 1'b0;
            r_smp_ch     <= 2'd0;
            r_smp_bit    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_smp_valid <= 1'b0;

            if (w_start) begin
                r_ch         <= w_pick_ch;
                r_gnt        <= 4'b0001 << w_pick_ch;
                r_mux_e      <= 1'b1;
                r_busy       <= 1'b1;
                r_settle_cnt <= c_settle_load;
            end

            if ((r_state == S_SETTLE) && (r_settle_cnt != '0)) begin
                r_settle_cnt <= r_settle_cnt - c_one;
            end

            // Dropping E and the grant here, while the select is only
            // changed on the next start, gives the disabled gap cycle.
            if (w_sample) begin
                r_smp_valid <= 1'b1;
                r_smp_ch    <= r_ch;
                r_smp_bit   <= mux_y;
                r_ptr       <= r_ch;
                r_mux_e     <= 1'b0;
                r_gnt       <= 4'b0000;
                r_busy      <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel fault counter and sticky alarm. An alarm being set wins
    // over a simultaneous clear, leaving the counter at threshold.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < 4; i++) begin : g_chan
        logic [CNT_W-1:0] r_cnt;
        logic             r_alm;
        logic             w_hit;
        logic             w_set;
        logic [CNT_W-1:0] w_inc;

        assign w_hit = w_sample && (r_ch == 2'(i));
        assign w_inc = (r_cnt >= c_thresh) ? c_thresh : (r_cnt + c_one);
        assign w_set = w_hit && mux_y && (w_inc == c_thresh);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
                r_alm <= 1'b0;
            end else if (w_set) begin
                r_cnt <= c_thresh;
                r_alm <= 1'b1;
            end else if (alarm_clr[i]) begin
                r_cnt <= '0;
                r_alm <= 1'b0;
            end else if (w_hit) begin
                r_cnt <= mux_y ? w_inc : '0;
            end
        end

        assign w_alarm[i] = r_alm;
    end

    assign mux_s0    = r_ch[0];
    assign mux_s1    = r_ch[1];
    assign mux_e     = r_mux_e;
    assign gnt       = r_gnt;
    assign busy      = r_busy;
    assign smp_valid = r_smp_valid;
    assign smp_ch    = r_smp_ch;
    assign smp_bit   = r_smp_bit;
    assign alarm     = w_alarm;

endmodule
`default_nettype wire

// File: tb/tb_health_mux_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_health_mux_scheduler
// Purpose  : Self-checking bench for health_mux_scheduler. Directed scenarios
//            followed by randomized transactions, all checked against a
//            transaction-level model of arbitration, fault counting and
//            alarms. Outputs are sampled 1 time unit after the rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_health_mux_scheduler;

    localparam int S  = 2;
    localparam int TH = 3;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic       mux_y;
    logic       mux_s0;
    logic       mux_s1;
    logic       mux_e;
    logic [3:0] gnt;
    logic       busy;
    logic       smp_valid;
    logic [1:0] smp_ch;
    logic       smp_bit;
    logic [3:0] alarm;
    logic [3:0] alarm_clr;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int       m_ptr;
    int       m_cnt [4];
    bit [3:0] m_alarm;

    health_mux_scheduler #(
        .SETTLE_CYCLES(S),
        .ALARM_THRESH (TH),
        .CNT_W        (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req      (req),
        .mux_y    (mux_y),
        .mux_s0   (mux_s0),
        .mux_s1   (mux_s1),
        .mux_e    (mux_e),
        .gnt      (gnt),
        .busy     (busy),
        .smp_valid(smp_valid),
        .smp_ch   (smp_ch),
        .smp_bit  (smp_bit),
        .alarm    (alarm),
        .alarm_clr(alarm_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // First requester in scan order from the last-served channel.
    function automatic int pick(input bit [3:0] r, input int p);
`ifdef HEALTH_SCHED_FIXED_PRIORITY_EN
        for (int c = 0; c < 4; c++) if (r[c]) return c;
`else
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (p + k) % 4;
            if (r[c]) return c;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr   = 3;
        m_alarm = 4'b0000;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},   32'(gnt), 0);
        chk({tag, "_e"},     32'(mux_e), 0);
        chk({tag, "_sel"},   32'({mux_s1, mux_s0}), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_valid"}, 32'(smp_valid), 0);
        chk({tag, "_ch"},    32'(smp_ch), 0);
        chk({tag, "_bit"},   32'(smp_bit), 0);
        chk({tag, "_alarm"}, 32'(alarm), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; req = 4'b0000; alarm_clr = 4'b0000; mux_y = 1'b0;
        tick();
        chk_all_zero("rst1");
        tick();
        chk_all_zero("rst2");
        rst = 1'b0;
        model_reset();
    endtask

    // Idle cycles with the given en/req; no transaction may start.
    task automatic idle_cycles(input int n, input bit e, input bit [3:0] r);
        en = e; req = r; alarm_clr = 4'b0000;
        for (int k = 0; k < n; k++) begin
            mux_y = 1'($urandom);
            tick();
            chk("idle_busy",  32'(busy), 0);
            chk("idle_gnt",   32'(gnt), 0);
            chk("idle_e",     32'(mux_e), 0);
            chk("idle_valid", 32'(smp_valid), 0);
        end
    endtask

    // One full transaction, entered and left in an IDLE cycle.
    task automatic run_txn(input bit [3:0] r, input bit [3:0] clr0, input bit en_mid,
                           input bit [3:0] r_mid, input bit ys, input bit [3:0] clr1);
        int ch;
        int nc;
        bit sets;
        ch = pick(r, m_ptr);
        chk("start_busy", 32'(busy), 0);
        chk("start_gnt",  32'(gnt), 0);
        chk("start_e",    32'(mux_e), 0);
        en = 1'b1; req = r; alarm_clr = clr0; mux_y = 1'($urandom);
        for (int i = 0; i < 4; i++) if (clr0[i]) begin m_cnt[i] = 0; m_alarm[i] = 1'b0; end
        tick();
        // S settle cycles plus the sample cycle hold grant, select and E.
        for (int k = 0; k <= S; k++) begin
            chk("txn_gnt",   32'(gnt), 1 << ch);
            chk("txn_e",     32'(mux_e), 1);
            chk("txn_busy",  32'(busy), 1);
            chk("txn_sel",   32'({mux_s1, mux_s0}), ch);
            chk("txn_valid", 32'(smp_valid), 0);
            chk("txn_alarm", 32'(alarm), 32'(m_alarm));
            en = en_mid; req = r_mid;
            if (k < S) begin
                alarm_clr = 4'b0000; mux_y = 1'($urandom);
            end else begin
                alarm_clr = clr1; mux_y = ys;
            end
            tick();
        end
        nc   = ys ? ((m_cnt[ch] + 1 > TH) ? TH : m_cnt[ch] + 1) : 0;
        sets = ys && (nc == TH);
        for (int i = 0; i < 4; i++) begin
            if (i == ch && sets) begin
                m_cnt[i] = TH; m_alarm[i] = 1'b1;
            end else if (clr1[i]) begin
                m_cnt[i] = 0; m_alarm[i] = 1'b0;
            end else if (i == ch) begin
                m_cnt[i] = nc;
            end
        end
        m_ptr = ch;
        chk("smp_valid", 32'(smp_valid), 1);
        chk("smp_ch",    32'(smp_ch), ch);
        chk("smp_bit",   32'(smp_bit), 32'(ys));
        chk("smp_alarm", 32'(alarm), 32'(m_alarm));
        chk("smp_gnt",   32'(gnt), 0);
        chk("smp_e",     32'(mux_e), 0);
        chk("smp_busy",  32'(busy), 0);
        en = en_mid; req = 4'b0000; alarm_clr = 4'b0000; mux_y = 1'($urandom);
    endtask

    initial begin
        do_reset();

        // Round robin with all channels requesting: 0,1,2,3,0 back to back.
        for (int n = 0; n < 5; n++) run_txn(4'b1111, 4'b0000, 1'b1, 4'b1111, 1'b0, 4'b0000);
        chk("rr_last_ch", 32'(smp_ch), 0);

        // Select mapping for channel 2; select held while E is high.
        run_txn(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 4'b0000);
        idle_cycles(1, 1'b1, 4'b0000);
        run_txn(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b0, 4'b0000);

        // Alarm threshold: 1,1,0,1,1 then the sixth 1 raises alarm[2].
        run_txn(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 4'b0000);
        run_txn(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 4'b0000);
        run_txn(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b0, 4'b0000);
        run_txn(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 4'b0000);
        run_txn(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 4'b0000);
        chk("alarm2_before", 32'(alarm[2]), 0);
        run_txn(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 4'b0000);
        chk("alarm2_set", 32'(alarm[2]), 1);
        run_txn(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b0, 4'b0000);
        chk("alarm2_sticky", 32'(alarm[2]), 1);

        // Clear/set collision on the third consecutive fault: set wins.
        run_txn(4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 4'b0000);
        run_txn(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 4'b0000);
        run_txn(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 4'b0100);
        chk("collide_alarm", 32'(alarm[2]), 1);
        // Later clear drops alarm and counter; two faults then stay below.
        run_txn(4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 4'b0000);
        chk("clr_alarm", 32'(alarm[2]), 0);
        run_txn(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 4'b0000);
        chk("clr_cnt_zero", 32'(alarm[2]), 0);

        // Reset held two cycles mid-SETTLE: no sample, ch0 granted next.
        en = 1'b1; req = 4'b1111; alarm_clr = 4'b0000;
        tick();
        chk("mid_busy", 32'(busy), 1);
        rst = 1'b1;
        tick();
        chk_all_zero("midrst1");
        tick();
        chk_all_zero("midrst2");
        rst = 1'b0;
        model_reset();
        run_txn(4'b1111, 4'b0000, 1'b1, 4'b1111, 1'b0, 4'b0000);
        chk("post_rst_ch", 32'(smp_ch), 0);

        // Enable drop in the first SETTLE cycle: exactly one sample, then idle.
        do_reset();
        run_txn(4'b0011, 4'b0000, 1'b0, 4'b0011, 1'b1, 4'b0000);
        chk("endrop_ch", 32'(smp_ch), 0);
        idle_cycles(4, 1'b0, 4'b0011);

        // Randomized transactions against the model.
        for (int n = 0; n < 60; n++) begin
            bit [3:0] r;
            bit [3:0] r_mid;
            bit [3:0] c0;
            bit [3:0] c1;
            bit       em;
            bit       ys;
            r     = 4'($urandom_range(1, 15));
            r_mid = 4'($urandom_range(0, 15));
            c0    = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            c1    = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            em    = ($urandom_range(0, 3) != 0);
            ys    = ($urandom_range(0, 3) != 0);
            run_txn(r, c0, em, r_mid, ys, c1);
            if ($urandom_range(0, 4) == 0) idle_cycles(1, 1'b1, 4'b0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
